// File: rtl/neuron_argmax.sv
// neuron_argmax
//   Streams one signed neuron result per accepted beat (class order 0..N_CLASSES-1)
//   and tracks the running maximum and its class index. Once the last class has
//   been accepted it holds the winning index/value on a valid/ready output.
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start_     opens a new frame (IDLE or COLLECT); ignored in DONE
//   in_valid   in_data holds a neuron result
//   in_data    signed neuron result
//   in_ready   high in COLLECT
//   out_valid  high in DONE
//   out_ready  consumer takes the result
//   out_index  winning class index
//   out_value  winning (maximum) value, signed
//   busy       high in COLLECT or DONE
//   end_       one-cycle pulse after the result handshake
module neuron_argmax #(
   parameter int DATA_W    = 33,
   parameter int N_CLASSES = 10,
   parameter int IDX_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [DATA_W-1:0] out_value,
   output logic              busy,
   output logic              end_
);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]         LAST    = IDX_W'(N_CLASSES - 1);

   state_t                    state, state_nxt;
   logic [IDX_W-1:0]          count;
   logic signed [DATA_W-1:0]  best_val;
   logic [IDX_W-1:0]          best_idx;
   logic                      accept;

   assign accept = in_valid & (state == COLLECT);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_) state_nxt = COLLECT;
         // an abort restarts the frame, so it never completes in the same cycle
         COLLECT: if (!start_ && accept && count == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // running maximum; also drives the held result while in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         best_val <= '0;
         best_idx <= '0;
      end else if (state == IDLE) begin
         if (start_) begin
            count    <= '0;
            best_val <= MIN_VAL;
            best_idx <= '0;
         end
      end else if (state == COLLECT) begin
         if (start_) begin
            // abort: a beat arriving with start_ is class 0 of the new frame,
            // and anything beats MIN_VAL or equals it, so it is the best so far
            best_idx <= '0;
            if (in_valid) begin
               count    <= IDX_W'(1);
               best_val <= $signed(in_data);
            end else begin
               count    <= '0;
               best_val <= MIN_VAL;
            end
         end else if (accept) begin
            // strict compare keeps the lower index on ties
            if ($signed(in_data) > best_val) begin
               best_val <= $signed(in_data);
               best_idx <= count;
            end
            if (count != LAST) count <= count + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) end_ <= 1'b0;
      else     end_ <= (state == DONE) && out_ready;
   end

   assign out_index = best_idx;
   assign out_value = best_val;

endmodule

// File: tb/tb_neuron_argmax.sv
module tb_neuron_argmax;

   typedef longint frame_t [10];

   logic        clk = 1'b0;
   logic        rst;
   logic        start_;
   logic        in_valid;
   logic [32:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_index;
   logic [32:0] out_value;
   logic        busy;
   logic        end_;

   int n_cmp = 0;
   int n_err = 0;

   neuron_argmax #(.DATA_W(33), .N_CLASSES(10), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .start_(start_),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_value(out_value),
      .busy(busy), .end_(end_)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds a frame; abort_after>0 sends that many beats of junk first and then
   // restarts with start_ and class 0 of the real frame in the same cycle.
   task automatic send_frame(input frame_t v, input bit stalls, input int abort_after);
      int first;
      first = 0;
      start_ = 1'b1;
      tick();
      start_ = 1'b0;
      chk("collect_in_ready", in_ready, 1);
      if (abort_after > 0) begin
         for (int i = 0; i < abort_after; i++) begin
            in_valid = 1'b1;
            in_data  = 33'd1000 + 33'(i);
            tick();
         end
         start_   = 1'b1;
         in_valid = 1'b1;
         in_data  = v[0][32:0];
         tick();
         start_ = 1'b0;
         first  = 1;
      end
      for (int i = first; i < 10; i++) begin
         if (stalls) begin
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'b0;
               in_data  = 33'd999;
               tick();
            end
         end
         in_valid = 1'b1;
         in_data  = v[i][32:0];
         if (i == 9) chk("no_early_valid", out_valid, 0);
         tick();
      end
      in_valid = 1'b0;
      chk("valid_after_last", out_valid, 1);
   endtask

   // Holds out_ready low for 'hold' cycles (pushing beats and optional start_)
   // while checking stability, then completes the handshake and checks end_.
   task automatic take_result(input string tag, input int exp_idx, input longint exp_val,
                              input int hold, input bit poke_start);
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1;
         in_data  = 33'd500;
         start_   = poke_start;
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_ready"}, in_ready, 0);
         chk({tag, "_hold_idx"}, 33'(out_index), 33'(exp_idx));
         chk({tag, "_hold_val"}, out_value, exp_val[32:0]);
         tick();
      end
      in_valid  = 1'b0;
      start_    = 1'b0;
      chk({tag, "_idx"}, 33'(out_index), 33'(exp_idx));
      chk({tag, "_val"}, out_value, exp_val[32:0]);
      chk({tag, "_busy"}, busy, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_end"}, end_, 1);
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_idle"}, busy, 0);
      tick();
      chk({tag, "_end_once"}, end_, 0);
   endtask

   initial begin
      frame_t f;
      rst = 1'b1; start_ = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_end", end_, 0);
      chk("rst_idx", 33'(out_index), 0);
      chk("rst_val", out_value, 0);

      // T1: reset in the middle of COLLECT
      start_ = 1'b1; tick(); start_ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 33'(i + 20); tick();
      end
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("t1_in_ready", in_ready, 0);
      chk("t1_out_valid", out_valid, 0);
      chk("t1_busy", busy, 0);
      chk("t1_idx", 33'(out_index), 0);
      chk("t1_val", out_value, 0);
      chk("t1_end", end_, 0);
      tick();
      in_valid = 1'b0;
      chk("t1_stay_idle", busy, 0);

      // T2 basic, then T6 back-to-back with no carry-over of 12
      f = '{0, 5, -3, 12, 7, 1, 0, 2, 11, 4};
      send_frame(f, 0, 0);
      take_result("t2", 3, 12, 0, 0);
      f = '{-10, -20, -5, -30, -6, -8, -9, -11, -12, -40};
      send_frame(f, 0, 0);
      take_result("t6", 2, -5, 0, 0);

      // T3 ties and negatives
      f = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
      send_frame(f, 0, 0);
      take_result("t3_all_m7", 0, -7, 0, 0);
      f = '{0, 1, 3, -1, 2, 0, -5, 1, 3, 2};
      send_frame(f, 0, 0);
      take_result("t3_tie", 2, 3, 0, 0);
      for (int i = 0; i < 10; i++) f[i] = -64'sd4294967296;
      send_frame(f, 0, 0);
      take_result("t3_min", 0, -64'sd4294967296, 0, 0);

      // T4 stalls and backpressure, same data as T2
      f = '{0, 5, -3, 12, 7, 1, 0, 2, 11, 4};
      send_frame(f, 1, 0);
      take_result("t4", 3, 12, 5, 0);

      // T5 abort after 4 beats, then start_ held during DONE
      f = '{1, 2, 0, -4, 3, 5, 9, 8, -1, 9};
      send_frame(f, 0, 4);
      take_result("t5", 6, 9, 3, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
